// File: rtl/branch_cc_fsm_pkg.sv
// Shared types and helpers for the condition-code / branch-resolution sequencer.
package branch_cc_fsm_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_BRANCH = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'b00,
        PC_INC    = 2'b01,
        PC_BRANCH = 2'b10,
        PC_JUMP   = 2'b11
    } pc_ctl_e;

    localparam logic [2:0] CC_RESET = 3'b010;

    // Result is zero-extended to 64 bits by the caller; msb_idx marks its real sign bit.
    function automatic logic [2:0] nzp_of(input logic [63:0] result, input logic [5:0] msb_idx);
        logic [2:0] cc_s;
        if (result == 64'd0) begin
            cc_s = 3'b010;
        end else if (result[msb_idx]) begin
            cc_s = 3'b100;
        end else begin
            cc_s = 3'b001;
        end
        return cc_s;
    endfunction

endpackage

// File: rtl/branch_cc_eval.sv
// Combinational branch resolution: taken flag, next PC and PC-update code.
module branch_cc_eval
    import branch_cc_fsm_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
) (
    input  logic [2:0]       mask,
    input  logic [2:0]       cc,
    input  logic             br,
    input  logic             jmp,
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    output logic             taken,
    output logic [PC_W-1:0]  next_pc,
    output logic [1:0]       pc_ctl
);

    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] off_ext_s;

    // Jump wins over a conditional branch; arithmetic wraps modulo 2^PC_W.
    always_comb begin
        pc_inc_s  = pc + PC_W'(1'b1);
        off_ext_s = PC_W'($signed(offset));
        taken     = 1'b0;
        next_pc   = pc_inc_s;
        pc_ctl    = PC_INC;
        if (jmp) begin
            taken   = 1'b1;
            next_pc = target;
            pc_ctl  = PC_JUMP;
        end else if (br && (|(mask & cc))) begin
            taken   = 1'b1;
            next_pc = pc_inc_s + off_ext_s;
            pc_ctl  = PC_BRANCH;
        end else begin
            taken   = 1'b0;
            next_pc = pc_inc_s;
            pc_ctl  = PC_INC;
        end
    end

endmodule

// File: rtl/branch_cc_fsm.sv
// Fetch/decode/execute/branch sequencer owning the PC and the NZP condition register.
module branch_cc_fsm
    import branch_cc_fsm_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 16,
    parameter int              OFF_W    = 9,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(16'h3000)
) (
    input  logic              clka,
    input  logic              reset_in,
    input  logic              instr_valid_in,
    input  logic              n_dec_in,
    input  logic              z_dec_in,
    input  logic              p_dec_in,
    input  logic              br_in,
    input  logic              jmp_in,
    input  logic              halt_in,
    input  logic [OFF_W-1:0]  offset_in,
    input  logic [PC_W-1:0]   target_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic              we_reg_in,
    output logic [PC_W-1:0]   pc_out,
    output logic [2:0]        cc_out,
    output logic [1:0]        pc_ctl_out,
    output logic              taken_out,
    output logic              fetch_en_out,
    output logic [2:0]        state_out
);

    state_e           state_r, state_nx_s;
    logic [2:0]       mask_r, mask_nx_s;
    logic             br_r, br_nx_s;
    logic             jmp_r, jmp_nx_s;
    logic             halt_r, halt_nx_s;
    logic [OFF_W-1:0] offset_r, offset_nx_s;
    logic [PC_W-1:0]  target_r, target_nx_s;
    logic [PC_W-1:0]  pc_r, pc_nx_s;
    logic [2:0]       cc_r, cc_nx_s;
    logic [1:0]       pc_ctl_r, pc_ctl_nx_s;
    logic             taken_r, taken_nx_s;
    logic             fetch_en_r, fetch_en_nx_s;

    logic             eval_taken_s;
    logic [PC_W-1:0]  eval_pc_s;
    logic [1:0]       eval_ctl_s;

    branch_cc_eval #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_eval (
        .mask    (mask_r),
        .cc      (cc_r),
        .br      (br_r),
        .jmp     (jmp_r),
        .pc      (pc_r),
        .offset  (offset_r),
        .target  (target_r),
        .taken   (eval_taken_s),
        .next_pc (eval_pc_s),
        .pc_ctl  (eval_ctl_s)
    );

    // Next-state and next-register values; pc_ctl/taken default to idle each cycle.
    always_comb begin
        state_nx_s  = state_r;
        mask_nx_s   = mask_r;
        br_nx_s     = br_r;
        jmp_nx_s    = jmp_r;
        halt_nx_s   = halt_r;
        offset_nx_s = offset_r;
        target_nx_s = target_r;
        pc_nx_s     = pc_r;
        cc_nx_s     = cc_r;
        pc_ctl_nx_s = PC_HOLD;
        taken_nx_s  = 1'b0;
        case (state_r)
            ST_RESET: begin
                state_nx_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid_in) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                mask_nx_s   = {n_dec_in, z_dec_in, p_dec_in};
                br_nx_s     = br_in;
                jmp_nx_s    = jmp_in;
                halt_nx_s   = halt_in;
                offset_nx_s = offset_in;
                target_nx_s = target_in;
                state_nx_s  = ST_EXEC;
            end
            ST_EXEC: begin
                if (we_reg_in) begin
                    cc_nx_s = nzp_of(64'(alu_result_in), 6'(DATA_W - 1));
                end else begin
                    cc_nx_s = cc_r;
                end
                if (halt_r) begin
                    state_nx_s = ST_HALT;
                end else if (jmp_r || br_r) begin
                    state_nx_s = ST_BRANCH;
                end else begin
                    pc_nx_s     = pc_r + PC_W'(1'b1);
                    pc_ctl_nx_s = PC_INC;
                    state_nx_s  = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                // cc_r already holds any update made in EXEC of this instruction.
                pc_nx_s     = eval_pc_s;
                pc_ctl_nx_s = eval_ctl_s;
                taken_nx_s  = eval_taken_s;
                state_nx_s  = ST_FETCH;
            end
            ST_HALT: begin
                state_nx_s = ST_HALT;
            end
            default: begin
                state_nx_s = ST_RESET;
            end
        endcase
        fetch_en_nx_s = (state_nx_s == ST_FETCH);
    end

    // State, latched decode fields and registered outputs.
    always_ff @(posedge clka or posedge reset_in) begin
        if (reset_in) begin
            state_r    <= ST_RESET;
            mask_r     <= 3'b000;
            br_r       <= 1'b0;
            jmp_r      <= 1'b0;
            halt_r     <= 1'b0;
            offset_r   <= '0;
            target_r   <= '0;
            pc_r       <= RESET_PC;
            cc_r       <= CC_RESET;
            pc_ctl_r   <= PC_HOLD;
            taken_r    <= 1'b0;
            fetch_en_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            mask_r     <= mask_nx_s;
            br_r       <= br_nx_s;
            jmp_r      <= jmp_nx_s;
            halt_r     <= halt_nx_s;
            offset_r   <= offset_nx_s;
            target_r   <= target_nx_s;
            pc_r       <= pc_nx_s;
            cc_r       <= cc_nx_s;
            pc_ctl_r   <= pc_ctl_nx_s;
            taken_r    <= taken_nx_s;
            fetch_en_r <= fetch_en_nx_s;
        end
    end

    assign pc_out       = pc_r;
    assign cc_out       = cc_r;
    assign pc_ctl_out   = pc_ctl_r;
    assign taken_out    = taken_r;
    assign fetch_en_out = fetch_en_r;
    assign state_out    = state_r;

endmodule
